// File: rtl/m_mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Define MEM_RESPONDER_BYTE_ENABLE_EN to make stores honour w_req_be.
module m_mem_responder #(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic              w_req_we,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [31:0]       w_req_wdata,
    input  logic [3:0]        w_req_be,
    output logic              w_rsp_valid,
    input  logic              w_rsp_ready,
    output logic [31:0]       w_rsp_rdata,
    output logic              w_rsp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT = 4'(LATENCY);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              live;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [31:0]       wmask;
    logic [IW-1:0]     idx;
    logic              in_range;
    logic              accept;
    logic              commit;
    logic [31:0]       rd_word;

    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    assign w_req_ready = live && (state == IDLE);
    assign w_rsp_valid = (state == RESP);
    assign accept      = w_req_valid && w_req_ready;

    // With zero latency the access happens on the accept edge itself,
    // so the live request fields are used instead of the latched copy.
    always_comb begin
        a_we    = we_q;
        a_addr  = addr_q;
        a_wdata = wdata_q;
        if (state == IDLE) begin
            a_we    = w_req_we;
            a_addr  = w_req_addr;
            a_wdata = w_req_wdata;
        end
    end

`ifdef MEM_RESPONDER_BYTE_ENABLE_EN
    logic [3:0] be_q;
    logic [3:0] a_be;

    assign a_be  = (state == IDLE) ? w_req_be : be_q;
    assign wmask = {{8{a_be[3]}}, {8{a_be[2]}}, {8{a_be[1]}}, {8{a_be[0]}}};

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            be_q <= 4'h0;
        end else if (accept) begin
            be_q <= w_req_be;
        end
    end
`else
    logic unused_be;

    assign unused_be = ^w_req_be;
    assign wmask     = 32'hFFFF_FFFF;
`endif

    assign idx      = a_addr[IW-1:0];
    assign in_range = {1'b0, a_addr} < DEPTH_V;
    assign commit   = (state == WAIT && cnt == 4'd1) ||
                      (accept && LATENCY == 0);
    assign rd_word  = (in_range && !a_we) ? mem[idx] : 32'h0;

    always_ff @(posedge w_clk) begin
        if (commit && a_we && in_range) begin
            mem[idx] <= (mem[idx] & ~wmask) | (a_wdata & wmask);
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            live        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            w_rsp_rdata <= 32'h0;
            w_rsp_err   <= 1'b0;
        end else begin
            live <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= w_req_we;
                        addr_q  <= w_req_addr;
                        wdata_q <= w_req_wdata;
                        if (LATENCY == 0) begin
                            state       <= RESP;
                            w_rsp_rdata <= rd_word;
                            w_rsp_err   <= !in_range;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state       <= RESP;
                        w_rsp_rdata <= rd_word;
                        w_rsp_err   <= !in_range;
                    end
                end
                RESP: begin
                    if (w_rsp_ready) begin
                        state       <= IDLE;
                        w_rsp_rdata <= 32'h0;
                        w_rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_mem_responder.sv
// Directed bench for m_mem_responder: one LATENCY=2 instance and one
// LATENCY=0 instance, both DEPTH=1024, sharing clock and reset.
module tb_m_mem_responder;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_we;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [11:0] b_req_addr;
    logic [31:0] b_req_wdata;
    logic [3:0]  b_req_be;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    m_mem_responder #(.ADDR_W(12), .DEPTH(1024), .LATENCY(2)) dut (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_req_valid(req_valid), .w_req_ready(req_ready),
        .w_req_we(req_we), .w_req_addr(req_addr),
        .w_req_wdata(req_wdata), .w_req_be(req_be),
        .w_rsp_valid(rsp_valid), .w_rsp_ready(rsp_ready),
        .w_rsp_rdata(rsp_rdata), .w_rsp_err(rsp_err)
    );

    m_mem_responder #(.ADDR_W(12), .DEPTH(1024), .LATENCY(0)) dut0 (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_req_valid(b_req_valid), .w_req_ready(b_req_ready),
        .w_req_we(b_req_we), .w_req_addr(b_req_addr),
        .w_req_wdata(b_req_wdata), .w_req_be(b_req_be),
        .w_rsp_valid(b_rsp_valid), .w_rsp_ready(b_rsp_ready),
        .w_rsp_rdata(b_rsp_rdata), .w_rsp_err(b_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output logic er,
                          output int lat);
        int k;
        @(negedge clk);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("accept_timeout", 32'(k), 0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          k;
    int          acc [4];
    logic        ops_we [4];
    logic [11:0] ops_addr [4];
    logic [31:0] ops_data [4];
    logic [31:0] exp7;

    initial begin
`ifdef MEM_RESPONDER_BYTE_ENABLE_EN
        exp7 = 32'h11BB33DD;
`else
        exp7 = 32'hAABBCCDD;
`endif
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = 4'h0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0;
        b_req_wdata = '0; b_req_be = 4'hF; b_rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 1);
        check("post_rst_b_req_ready", 32'(b_req_ready), 1);

        do_req(1'b1, 12'd5, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check("st5_lat", 32'(lat), 3);
        check("st5_err", 32'(er), 0);
        check("st5_rdata", rd, 0);
        do_req(1'b0, 12'd5, 32'h0, 4'hF, rd, er, lat);
        check("ld5_lat", 32'(lat), 3);
        check("ld5_rdata", rd, 32'hDEADBEEF);
        check("ld5_err", 32'(er), 0);

        do_req(1'b1, 12'd7, 32'h11223344, 4'hF, rd, er, lat);
        do_req(1'b1, 12'd7, 32'hAABBCCDD, 4'h5, rd, er, lat);
        do_req(1'b0, 12'd7, 32'h0, 4'hF, rd, er, lat);
        check("ld7_be_rdata", rd, exp7);

        do_req(1'b1, 12'd0, 32'hCAFEF00D, 4'hF, rd, er, lat);
        do_req(1'b0, 12'h400, 32'h0, 4'hF, rd, er, lat);
        check("ld400_err", 32'(er), 1);
        check("ld400_rdata", rd, 0);
        do_req(1'b1, 12'h400, 32'h55555555, 4'hF, rd, er, lat);
        check("st400_err", 32'(er), 1);
        do_req(1'b0, 12'd0, 32'h0, 4'hF, rd, er, lat);
        check("ld0_after_oob", rd, 32'hCAFEF00D);
        check("ld0_err", 32'(er), 0);

        // Backpressure: hold the response, keep a second load pending.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 12'd5; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        req_addr = 12'd7;
        k = 0;
        while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) check("stall_rsp_timeout", 32'(k), 0);
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 1);
            check("stall_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            check("stall_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_done_rsp_valid", 32'(rsp_valid), 0);
        check("stall_done_req_ready", 32'(req_ready), 1);
        @(negedge clk);
        check("second_accepted", 32'(req_ready), 0);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        check("second_lat", 32'(lat), 3);
        check("second_rdata", rsp_rdata, exp7);

        // Zero-latency instance: two stores then back-to-back loads.
        ops_we[0] = 1'b1; ops_addr[0] = 12'd1; ops_data[0] = 32'h0000_1111;
        ops_we[1] = 1'b1; ops_addr[1] = 12'd2; ops_data[1] = 32'h0000_2222;
        ops_we[2] = 1'b0; ops_addr[2] = 12'd1; ops_data[2] = 32'h0;
        ops_we[3] = 1'b0; ops_addr[3] = 12'd2; ops_data[3] = 32'h0;
        @(negedge clk);
        b_req_we = ops_we[0]; b_req_addr = ops_addr[0];
        b_req_wdata = ops_data[0]; b_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            @(negedge clk);
            while (!b_req_ready && k < 20) begin @(negedge clk); k++; end
            acc[i] = cyc;
            @(negedge clk);
            check("b_rsp_valid_1cyc", 32'(b_rsp_valid), 1);
            if (i >= 2) check("b_ld_rdata", b_rsp_rdata, ops_data[i-2]);
            else check("b_st_rdata", b_rsp_rdata, 0);
            if (i < 3) begin
                b_req_we = ops_we[i+1]; b_req_addr = ops_addr[i+1];
                b_req_wdata = ops_data[i+1];
            end else begin
                b_req_valid = 1'b0;
            end
        end
        for (int i = 1; i < 4; i++) check("b_period", 32'(acc[i] - acc[i-1]), 2);

        // Reset pulse in the middle of a store's wait phase.
        do_req(1'b1, 12'd9, 32'h0BADF00D, 4'hF, rd, er, lat);
        @(negedge clk);
        req_we = 1'b1; req_addr = 12'd9; req_wdata = 32'h12345678;
        req_be = 4'hF; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 0);
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        check("midrst_rsp_rdata", rsp_rdata, 0);
        check("midrst_rsp_err", 32'(rsp_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", 32'(req_ready), 1);
        do_req(1'b0, 12'd9, 32'h0, 4'hF, rd, er, lat);
        check("ld9_after_abort", rd, 32'h0BADF00D);
        check("ld9_lat", 32'(lat), 3);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/m_mem_responder.md
M_MEM_RESPONDER -- requirements
Module: m_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning word-address width.
REQ-002 The block SHALL have parameter DEPTH, default 4096, meaning number of implemented 32-bit words (DEPTH <= 2**ADDR_W).
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and response (legal range 0..15).
REQ-004 The block SHALL have port w_clk, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port w_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port w_req_valid, input, 1 bit: initiator presents a request.
REQ-007 The block SHALL have port w_req_ready, output, 1 bit: responder accepts a request this cycle.
REQ-008 The block SHALL have port w_req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port w_req_addr, input, ADDR_W bits: word address.
REQ-010 The block SHALL have port w_req_wdata, input, 32 bits: store data.
REQ-011 The block SHALL have port w_req_be, input, 4 bits: byte enables, bit n covers bits 8n+7..8n.
REQ-012 The block SHALL have port w_rsp_valid, output, 1 bit: response presented.
REQ-013 The block SHALL have port w_rsp_ready, input, 1 bit: initiator accepts the response.
REQ-014 The block SHALL have port w_rsp_rdata, output, 32 bits: load data (0 for stores and errors).
REQ-015 The block SHALL have port w_rsp_err, output, 1 bit: address >= DEPTH.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 In IDLE, w_req_ready SHALL be 1; a request is accepted on a rising edge with w_req_valid=1 and w_req_ready=1, which latches we/addr/wdata/be.
REQ-018 On acceptance, the FSM SHALL go to WAIT and load a down-counter with LATENCY; with LATENCY=0 it SHALL go directly to RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle; on reaching 0 the FSM SHALL enter RESP on the next edge.
REQ-020 The memory access (read sample or write commit) SHALL occur on the WAIT->RESP (or IDLE->RESP) transition edge.
REQ-021 In RESP, w_rsp_valid SHALL be 1 and rdata/err SHALL stay stable until w_rsp_valid and w_rsp_ready are both 1 on an edge, after which the FSM SHALL return to IDLE.
REQ-022 w_req_ready SHALL be 0 in WAIT and RESP; at most one transaction SHALL be outstanding; requests are never dropped, only stalled.
REQ-023 A load SHALL return the word as stored, including stores committed by any earlier completed transaction.
REQ-024 For addr >= DEPTH: err=1, rdata=0, no memory write.
REQ-025 A request asserted in the same cycle the prior response completes SHALL NOT be accepted until the next cycle (IDLE).
REQ-026 Memory contents SHALL initialise to 0 at time zero and SHALL NOT be cleared by reset.

Reset
REQ-027 When w_rst_n=0, the FSM SHALL enter IDLE immediately; the counter SHALL be 0; w_rsp_valid, w_rsp_err, and w_rsp_rdata SHALL be 0; and w_req_ready SHALL be 0 while reset is asserted and SHALL be 1 from the first edge after deassertion.
REQ-028 Reset asserted during WAIT SHALL abort the transaction with no memory write.

Configuration
REQ-029 With macro MEM_RESPONDER_BYTE_ENABLE_EN defined, a store SHALL write only the bytes whose w_req_be bit is 1.
REQ-030 Without MEM_RESPONDER_BYTE_ENABLE_EN, w_req_be SHALL be ignored and every store SHALL write all 32 bits.

Verification
REQ-031 The bench SHALL cover: LATENCY=2, store addr 5 data 0xDEADBEEF be 0xF, then load addr 5 -> rsp_valid 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-032 The bench SHALL cover: with BYTE_ENABLE_EN, after word 0x11223344 at addr 7, store 0xAABBCCDD be 0x5, then load addr 7 -> 0x11BB33DD; without the macro -> 0xAABBCCDD.
REQ-033 The bench SHALL cover: DEPTH=1024, load addr 0x400 -> err 1, rdata 0; a store to 0x400 leaves addr 0 unchanged.
REQ-034 The bench SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready 0, and a second request waits and is accepted the cycle after the first response completes.
REQ-035 The bench SHALL cover: LATENCY=0 with back-to-back loads at addr 1 and 2 -> each response 1 cycle after accept, one transaction per 2 cycles.
REQ-036 The bench SHALL cover: w_rst_n pulsed low mid-WAIT of a store 0x12345678 to addr 9 -> outputs 0 immediately, and a subsequent load of addr 9 returns its previous value.
